// File: rtl/qpsk_uart_tx_ctrl_pkg.sv
// Shared types and constants for the QPSK BRAM-to-UART transmit controller.
// QPSK_TX_HDR_EN adds the two-byte frame header state.
package qpsk_tx_pkg;

    localparam int         BYTES_PER_PAIR = 3;
    localparam int         PAIR_CNT_W     = 14;
    localparam logic [7:0] HDR_BYTE0      = 8'hEB;
    localparam logic [7:0] HDR_BYTE1      = 8'h90;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_RD = 3'd1,
        LOAD    = 3'd2,
        SEND    = 3'd3,
        DONE24  = 3'd4,
        FINISH  = 3'd5
`ifdef QPSK_TX_HDR_EN
        ,
        HDR     = 3'd6
`endif
    } tx_state_e;

    // Port-a (even address) sample lands in the upper half, so it is sent first.
    typedef struct packed {
        logic [11:0] a;
        logic [11:0] b;
    } iq_pair_t;

endpackage

// File: rtl/qpsk_uart_tx_ctrl_if.sv
// Byte-level valid/ready link between the transmit controller and the UART byte transmitter.
interface qpsk_uart_tx_ctrl_if;
    logic       uart_byte_valid;
    logic [7:0] uart_byte_data;
    logic       uart_byte_ready;

    modport master (output uart_byte_valid, output uart_byte_data, input uart_byte_ready);
    modport slave  (input uart_byte_valid, input uart_byte_data, output uart_byte_ready);
endinterface

// File: rtl/qpsk_uart_tx_ctrl_serializer.sv
// Loads one 24-bit I/Q pair and shifts it out MSB byte first under valid/ready,
// flagging the cycle in which the last byte is accepted.
module qpsk_byte_serializer
    import qpsk_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  iq_pair_t   din,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] data,
    output logic       done
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_PAIR - 1);

    logic [23:0] shreg;
    logic [1:0]  byte_idx;
    logic        busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
        end else if (load) begin
            shreg    <= din;
            byte_idx <= '0;
            busy     <= 1'b1;
        end else if (busy && ready) begin
            shreg <= {shreg[15:0], 8'h00};
            if (byte_idx == LAST_IDX) begin
                busy     <= 1'b0;
                byte_idx <= '0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    assign valid = busy;
    assign data  = shreg[23:16];
    // Combinational so the FSM leaves SEND on the same edge as the last transfer.
    assign done  = busy && ready && (byte_idx == LAST_IDX);

endmodule

// File: rtl/qpsk_uart_tx_ctrl.sv
// Streams PAIR_NUM stored I/Q pairs from the QPSK output BRAM to the UART, 3 bytes per pair.
// QPSK_TX_HDR_EN prefixes the frame with 0xEB 0x90.
module qpsk_uart_tx_ctrl
    import qpsk_tx_pkg::*;
#(
    parameter int PAIR_NUM   = 10000,
    parameter int RD_LATENCY = 2
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                qpsk_signal_wr_over,
    input  logic [11:0]         ram_rd_data_a,
    input  logic [11:0]         ram_rd_data_b,
    qpsk_uart_tx_ctrl_if.master uart,
    output logic                uart_tx_start,
    output logic                uart_tx_24_done,
    output logic                tx_frame_done
);

    localparam int                    LAT_W     = $clog2(RD_LATENCY + 2);
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(RD_LATENCY);
    localparam logic [PAIR_CNT_W-1:0] PAIR_LAST = PAIR_CNT_W'(PAIR_NUM - 1);

    tx_state_e             state, state_nxt;
    logic [PAIR_CNT_W-1:0] pair_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic                  ser_load, ser_valid, ser_done;
    logic [7:0]            ser_data;
    iq_pair_t              pair_w;

    assign pair_w = '{a: ram_rd_data_a, b: ram_rd_data_b};

    qpsk_byte_serializer u_ser (
        .clk   (clk),
        .rst   (rst),
        .load  (ser_load),
        .din   (pair_w),
        .ready (uart.uart_byte_ready),
        .valid (ser_valid),
        .data  (ser_data),
        .done  (ser_done)
    );

`ifdef QPSK_TX_HDR_EN
    logic       hdr_idx;
    logic       hdr_valid;
    logic [7:0] hdr_data;

    always_ff @(posedge clk) begin
        if (rst)
            hdr_idx <= 1'b0;
        else if (state == HDR && uart.uart_byte_ready)
            hdr_idx <= ~hdr_idx;
    end

    assign uart.uart_byte_valid = ser_valid | hdr_valid;
    assign uart.uart_byte_data  = hdr_valid ? hdr_data : ser_data;
`else
    assign uart.uart_byte_valid = ser_valid;
    assign uart.uart_byte_data  = ser_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pair_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            state <= state_nxt;
            // Counts 0..RD_LATENCY while waiting, parks at 0 otherwise.
            if (state == WAIT_RD && lat_cnt != LAT_LAST)
                lat_cnt <= lat_cnt + 1'b1;
            else
                lat_cnt <= '0;
            if (state == DONE24)
                pair_cnt <= pair_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        ser_load        = 1'b0;
        uart_tx_start   = 1'b0;
        uart_tx_24_done = 1'b0;
        tx_frame_done   = 1'b0;
`ifdef QPSK_TX_HDR_EN
        hdr_valid       = 1'b0;
        hdr_data        = 8'h00;
`endif
        case (state)
            IDLE: begin
                if (qpsk_signal_wr_over)
`ifdef QPSK_TX_HDR_EN
                    state_nxt = HDR;
`else
                    state_nxt = WAIT_RD;
`endif
            end
`ifdef QPSK_TX_HDR_EN
            HDR: begin
                uart_tx_start = 1'b1;
                hdr_valid     = 1'b1;
                hdr_data      = hdr_idx ? HDR_BYTE1 : HDR_BYTE0;
                if (uart.uart_byte_ready && hdr_idx)
                    state_nxt = WAIT_RD;
            end
`endif
            WAIT_RD: begin
                uart_tx_start = 1'b1;
                if (lat_cnt == LAT_LAST)
                    state_nxt = LOAD;
            end
            LOAD: begin
                uart_tx_start = 1'b1;
                ser_load      = 1'b1;
                state_nxt     = SEND;
            end
            SEND: begin
                uart_tx_start = 1'b1;
                if (ser_done)
                    state_nxt = DONE24;
            end
            DONE24: begin
                uart_tx_start   = 1'b1;
                uart_tx_24_done = 1'b1;
                state_nxt       = (pair_cnt == PAIR_LAST) ? FINISH : WAIT_RD;
            end
            FINISH: begin
                tx_frame_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
